// File: rtl/avalon_dct_mode_if.sv
// rtl/avalon_dct_mode_if.sv - Avalon-style slave bus bundle for the DCT accelerator
interface avalon_dct_mode_if #(
  parameter int NBITS = 16
);
  logic [7:0]              address;
  logic                    read;
  logic                    write;
  logic signed [NBITS-1:0] writedata;
  logic signed [NBITS-1:0] readdata;
  logic                    waitrequest;

  modport slave (
    input  address, read, write, writedata,
    output readdata, waitrequest
  );

  modport master (
    output address, read, write, writedata,
    input  readdata, waitrequest
  );
endinterface

// File: rtl/avalon_dct_mode.sv
// rtl/avalon_dct_mode.sv - memory-mapped DCT-II / DCT-III accelerator with MAC datapath
module avalon_dct_mode #(
  parameter int MAX_SIZE            = 64,
  parameter int NBITS               = 16,
  parameter int NUM_TERMS_PER_CYCLE = 8,
  parameter int ACC_BITS            = 40
) (
  input logic              clk,
  input logic              reset,
  avalon_dct_mode_if.slave bus
);
  localparam int LOGM  = $clog2(MAX_SIZE);
  localparam int T     = NUM_TERMS_PER_CYCLE;
  localparam int ROM_N = 4 * MAX_SIZE;
  localparam int IW    = LOGM + 2;
  localparam int CW    = LOGM + 1;
  localparam int HW    = ACC_BITS - NBITS + 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_WB, S_DONE} state_t;

  function automatic int cos_coef(int i);
    real v;
    v = $cos(3.14159265358979323846 * real'(i) / (2.0 * real'(MAX_SIZE)))
        * real'((1 << (NBITS - 1)) - 1);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  logic signed [NBITS-1:0] cosrom [ROM_N];
  for (genvar g = 0; g < ROM_N; g++) begin : g_rom
    localparam int C = cos_coef(g);
    assign cosrom[g] = NBITS'(C);
  end

  state_t                     state_q, state_d;
  logic [2:0]                 power_q, power_d;
  logic                       mode_q, mode_d;
  logic [3:0]                 shift_q, shift_d;
  logic [CW-1:0]              count_q, count_d;
  logic [LOGM-1:0]            k_q, k_d;
  logic [LOGM-1:0]            chunk_q, chunk_d;
  logic signed [ACC_BITS-1:0] acc_q, acc_d;
  logic [MAX_SIZE-1:0]        valid_q, valid_d;
  logic signed [NBITS-1:0]    samples_q [MAX_SIZE];
  logic signed [NBITS-1:0]    results_q [MAX_SIZE];

  logic                       ctrl_wr, data_wr, load_done, last_chunk, last_k;
  logic                       sample_we, result_we;
  logic [CW-1:0]              n_len;
  logic signed [ACC_BITS-1:0] mac_sum, bias, biased, rnd;
  logic [HW-1:0]              rnd_hi;
  logic signed [NBITS-1:0]    wb_val;
  logic [15:0]                status_w;
  logic                       res_in_range;
  logic [LOGM-1:0]            res_k;
  logic signed [NBITS-1:0]    rdata_c;
  logic                       wait_c;

  assign ctrl_wr    = bus.write && (bus.address == 8'h00);
  assign data_wr    = bus.write && (bus.address == 8'h01);
  assign n_len      = CW'(1) << power_q;
  assign load_done  = (state_q == S_LOAD) && data_wr && (count_q == n_len - CW'(1));
  assign last_chunk = ((int'(chunk_q) + 1) * T) >= int'(n_len);
  assign last_k     = ({1'b0, k_q} == n_len - CW'(1));

  // Up to T products per cycle; lanes past N contribute nothing.
  always_comb begin : p_mac
    int                      j_v, a_v, b_v;
    logic [IW-1:0]           rom_idx;
    logic signed [NBITS-1:0] op_v;
    logic signed [2*NBITS-1:0] prod_v;
    mac_sum = '0;
    for (int t = 0; t < T; t++) begin
      j_v     = int'(chunk_q) * T + t;
      a_v     = mode_q ? int'(k_q) : j_v;
      b_v     = mode_q ? j_v : int'(k_q);
      rom_idx = IW'(((2 * a_v + 1) * b_v) << (LOGM - int'(power_q)));
      op_v    = samples_q[LOGM'(j_v)];
      if (mode_q && (j_v == 0)) op_v = op_v >>> 1;
      prod_v  = op_v * cosrom[rom_idx];
      if (j_v < int'(n_len))
        mac_sum = mac_sum + {{(ACC_BITS-2*NBITS){prod_v[2*NBITS-1]}}, prod_v};
    end
  end

  always_comb begin
    bias   = ACC_BITS'(1) << (NBITS - 2 + int'(shift_q));
    biased = acc_q + bias;
    rnd    = biased >>> (NBITS - 1 + int'(shift_q));
    rnd_hi = rnd[ACC_BITS-1:NBITS-1];
    if ((&rnd_hi) || !(|rnd_hi))
      wb_val = rnd[NBITS-1:0];
    else if (rnd[ACC_BITS-1])
      wb_val = {1'b1, {(NBITS-1){1'b0}}};
    else
      wb_val = {1'b0, {(NBITS-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ctrl_wr) begin
      state_d = S_LOAD;
    end else begin
      case (state_q)
        S_LOAD:  if (load_done) state_d = S_MAC;
        S_MAC:   if (last_chunk) state_d = S_WB;
        S_WB:    state_d = last_k ? S_DONE : S_MAC;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    power_d   = power_q;
    mode_d    = mode_q;
    shift_d   = shift_q;
    count_d   = count_q;
    k_d       = k_q;
    chunk_d   = chunk_q;
    acc_d     = acc_q;
    valid_d   = valid_q;
    sample_we = 1'b0;
    result_we = 1'b0;
    // CTRL wins over everything, so an aborted block never writes another result.
    if (ctrl_wr) begin
      power_d = (int'(bus.writedata[2:0]) > LOGM) ? 3'(LOGM) : bus.writedata[2:0];
      mode_d  = bus.writedata[3];
      shift_d = bus.writedata[7:4];
      count_d = '0;
      valid_d = '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (data_wr) begin
            sample_we = 1'b1;
            count_d   = count_q + CW'(1);
          end
          if (load_done) begin
            k_d     = '0;
            chunk_d = '0;
            acc_d   = '0;
          end
        end
        S_MAC: begin
          acc_d   = acc_q + mac_sum;
          chunk_d = chunk_q + LOGM'(1);
        end
        S_WB: begin
          result_we      = 1'b1;
          valid_d[k_q]   = 1'b1;
          acc_d          = '0;
          chunk_d        = '0;
          if (!last_k) k_d = k_q + LOGM'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      power_q <= '0;
      mode_q  <= 1'b0;
      shift_q <= '0;
      count_q <= '0;
      k_q     <= '0;
      chunk_q <= '0;
      acc_q   <= '0;
      valid_q <= '0;
    end else begin
      power_q <= power_d;
      mode_q  <= mode_d;
      shift_q <= shift_d;
      count_q <= count_d;
      k_q     <= k_d;
      chunk_q <= chunk_d;
      acc_q   <= acc_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (sample_we) samples_q[count_q[LOGM-1:0]] <= bus.writedata;
    if (result_we) results_q[k_q] <= wb_val;
  end

  assign status_w     = {8'(count_q), 5'b0, mode_q, state_q == S_DONE,
                         (state_q == S_MAC) || (state_q == S_WB)};
  assign res_in_range = int'(bus.address[6:0]) < int'(n_len);
  assign res_k        = bus.address[LOGM-1:0];

  // A pending result stalls the read; the WB cycle forwards the value being written.
  always_comb begin
    rdata_c = '0;
    wait_c  = 1'b0;
    if (bus.read) begin
      if (bus.address == 8'h02) begin
        rdata_c = NBITS'(status_w);
      end else if (bus.address[7] && res_in_range &&
                   (state_q == S_MAC || state_q == S_WB || state_q == S_DONE)) begin
        if (valid_q[res_k])
          rdata_c = results_q[res_k];
        else if ((state_q == S_WB) && (res_k == k_q))
          rdata_c = wb_val;
        else if (state_q != S_DONE)
          wait_c = 1'b1;
      end
    end
  end

  assign bus.readdata    = rdata_c;
  assign bus.waitrequest = wait_c;
endmodule

// File: tb/tb_avalon_dct_mode.sv
// tb/tb_avalon_dct_mode.sv - randomized bench with a direct-formula DCT reference model
module tb_avalon_dct_mode;
  localparam int MAX = 64;
  localparam int NB  = 16;
  localparam int T   = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  avalon_dct_mode_if #(.NBITS(NB)) bus ();
  avalon_dct_mode dut (.clk(clk), .reset(reset), .bus(bus));

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;
  int rom [4*MAX];

  int m_n = 1, m_mode = 0, m_shift = 0, m_count = 0, m_start = 0;
  bit m_loading = 1'b0, m_started = 1'b0;
  int m_x   [MAX];
  int m_res [MAX];
  int s_rdata, s_wait;

  function automatic void check(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic int chunks();
    return (m_n + T - 1) / T;
  endfunction

  // Direct DCT sums over the block, then round and saturate.
  function automatic void model_compute();
    longint acc, r;
    int a, b, op;
    for (int k = 0; k < m_n; k++) begin
      acc = 0;
      for (int n = 0; n < m_n; n++) begin
        a  = m_mode ? k : n;
        b  = m_mode ? n : k;
        op = (m_mode && n == 0) ? (m_x[0] >>> 1) : m_x[n];
        acc += longint'(op) * longint'(rom[((2*a+1) * b * (MAX / m_n)) % (4*MAX)]);
      end
      r = (acc + (longint'(1) <<< (NB - 2 + m_shift))) >>> (NB - 1 + m_shift);
      m_res[k] = (r > 32767) ? 32767 : (r < -32768) ? -32768 : int'(r);
    end
  endfunction

  function automatic void model_apply(bit w, int a, logic [15:0] d);
    int p;
    if (!w) return;
    if (a == 0) begin
      p = int'(d[2:0]);
      if (p > 6) p = 6;
      m_n = 1 << p;
      m_mode = int'(d[3]);
      m_shift = int'(d[7:4]);
      m_count = 0;
      m_loading = 1'b1;
      m_started = 1'b0;
    end else if (a == 1 && m_loading) begin
      m_x[m_count] = int'($signed(d));
      m_count++;
      if (m_count == m_n) begin
        m_loading = 1'b0;
        m_started = 1'b1;
        m_start = cyc;
        model_compute();
      end
    end
  endfunction

  function automatic void model_expect(bit r, int a, output int ed, output int ew);
    int rel, c, total, k;
    bit busy, done;
    ed = 0;
    ew = 0;
    if (!r) return;
    rel   = cyc - m_start;
    c     = chunks();
    total = m_n * (c + 1);
    busy  = m_started && rel < total;
    done  = m_started && rel >= total;
    if (a == 2) begin
      ed = int'(busy) | (int'(done) << 1) | (m_mode << 2) | (m_count << 8);
    end else if (a >= 128) begin
      k = a - 128;
      if (m_started && k < m_n) begin
        if (rel >= k * (c + 1) + c) ed = m_res[k];
        else ew = 1;
      end
    end
  endfunction

  always @(negedge clk) begin : p_cmp
    int ed, ew;
    if (chk_en) begin
      model_expect(bus.read, int'(bus.address), ed, ew);
      check("waitrequest", int'(bus.waitrequest), ew);
      if (ew == 0) check("readdata", int'($signed(bus.readdata)), ed);
    end
  end

  task automatic cycle(input bit r, input bit w, input logic [7:0] a, input logic [15:0] d);
    bus.read = r;
    bus.write = w;
    bus.address = a;
    bus.writedata = d;
    @(negedge clk);
    s_rdata = int'($signed(bus.readdata));
    s_wait  = int'(bus.waitrequest);
    @(posedge clk);
    cyc++;
    model_apply(w, int'(a), d);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    cycle(1'b0, 1'b1, a, d);
  endtask

  task automatic rd(input logic [7:0] a);
    cycle(1'b1, 1'b0, a, 16'h0000);
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    forever begin
      rd(8'h02);
      if ((s_rdata & 2) != 0) break;
      n++;
      if (n >= bound) begin
        check("done_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic rand_cycle();
    int sel, r;
    logic [7:0] a;
    r   = $urandom_range(0, 99);
    sel = $urandom_range(0, 3);
    case (sel)
      0:       a = 8'h02;
      1:       a = 8'h80 + 8'($urandom_range(0, 127));
      2:       a = 8'($urandom_range(0, 255));
      default: a = 8'h80 + 8'($urandom_range(0, m_n - 1));
    endcase
    if (r < 8)
      cycle($urandom_range(0, 1) == 1, 1'b1, 8'h01, 16'($urandom));
    else if (r < 9)
      cycle($urandom_range(0, 1) == 1, 1'b1, 8'h00, 16'($urandom_range(0, 255)));
    else
      cycle($urandom_range(0, 4) != 0, 1'b0, a, 16'h0000);
  endtask

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : p_main
    int n, wcnt, nn;
    real v;
    logic [15:0] cw, smp;
    for (int i = 0; i < 4*MAX; i++) begin
      v = $cos(3.14159265358979323846 * real'(i) / (2.0 * real'(MAX))) * 32767.0;
      rom[i] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    end
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.address = 8'h00;
    bus.writedata = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_en = 1'b1;

    rd(8'h02);       check("reset_status", s_rdata, 0);
    rd(8'h80);       check("reset_result0", s_rdata, 0);
    check("reset_wait", s_wait, 0);
    wr(8'h01, 16'd55);
    rd(8'h02);       check("idle_data_ignored", s_rdata, 0);

    wr(8'h00, 16'h0002);
    repeat (4) wr(8'h01, 16'd1000);
    check("model_fwd_dc", m_res[0], 4000);
    wait_done(100, n);
    check("done_latency", n, 8);
    rd(8'h80);       check("fwd_dc", s_rdata, 4000);
    for (int k = 1; k < 4; k++) begin
      rd(8'h80 + 8'(k));
      check("fwd_ac_abs_le1", ((s_rdata < 0 ? -s_rdata : s_rdata) <= 1) ? 1 : 0, 1);
    end
    rd(8'h02);       check("status_done", s_rdata, 32'h0402);

    wr(8'h00, 16'h000A);
    wr(8'h01, 16'd2000);
    repeat (3) wr(8'h01, 16'd0);
    wait_done(100, n);
    for (int k = 0; k < 4; k++) begin
      rd(8'h80 + 8'(k));
      check("inv_flat", s_rdata, 1000);
    end

    wr(8'h00, 16'h0006);
    repeat (64) wr(8'h01, 16'd32767);
    wait_done(1000, n);
    rd(8'h80);       check("sat_dc", s_rdata, 32767);

    wr(8'h00, 16'h0066);
    repeat (64) wr(8'h01, 16'd32767);
    wcnt = 0;
    forever begin
      rd(8'h80 + 8'd63);
      if (s_wait == 0) break;
      wcnt++;
      if (wcnt > 2000) begin
        check("wait_timeout", 0, 1);
        break;
      end
    end
    check("wait_cycles", wcnt, 575);
    check("wait_data", s_rdata, m_res[63]);
    wait_done(100, n);
    rd(8'h80);       check("shift6_dc", s_rdata, 32766);

    wr(8'h00, 16'h0006);
    repeat (64) wr(8'h01, 16'($urandom));
    repeat (20) rd(8'h02);
    wr(8'h00, 16'h0001);
    rd(8'h02);       check("abort_status", s_rdata, 0);
    rd(8'h80);       check("abort_result", s_rdata, 0);
    check("abort_wait", s_wait, 0);
    wr(8'h01, 16'd100);
    wr(8'h01, 16'd100);
    wait_done(50, n);
    rd(8'h80);       check("abort_n2_r0", s_rdata, 200);
    rd(8'h81);       check("abort_n2_r1", s_rdata, 0);

    for (int blk = 0; blk < 12; blk++) begin
      cw = {8'h00, 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7))};
      wr(8'h00, cw);
      nn = m_n;
      for (int i = 0; i < nn; i++) begin
        if ($urandom_range(0, 3) == 0) rd(8'h80 + 8'($urandom_range(0, 127)));
        smp = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 511) - 256);
        wr(8'h01, smp);
      end
      for (int c = 0; c < nn * (chunks() + 1) + 4; c++) rand_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
